// File: rtl/amer_put_pkg.sv
// rtl/amer_put_pkg.sv - shared types and defaults for the American put run sequencer
package amer_put_pkg;

    localparam int DATA_W           = 64;
    localparam int N_W_DEF          = 16;
    localparam int DRAIN_CYCLES_DEF = 12;
    localparam int WDOG_W_DEF       = 24;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        WAIT_S1 = 3'd2,
        RUN     = 3'd3,
        DRAIN   = 3'd4,
        HOLD    = 3'd5,
        ERR     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - saturating no-progress counter for the run sequencer
module seq_watchdog
    import amer_put_pkg::*;
#(
    parameter int WDOG_W = WDOG_W_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    logic [WDOG_W-1:0] cnt;

    assign expired = &cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/amer_put_seq.sv
// rtl/amer_put_seq.sv - run sequencer: accept, stage-1 launch, level count, drain, result handshake
module amer_put_seq
    import amer_put_pkg::*;
#(
    parameter int N_W          = N_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int WDOG_W       = WDOG_W_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req,
    output logic              ack,
    input  logic [N_W-1:0]    n_steps,
    input  logic              abort,
    output logic              start_s1,
    input  logic              done_init,
    input  logic              done_s1,
    input  logic              step_done,
    input  logic [DATA_W-1:0] result_in,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              error,
    output logic [N_W-1:0]    steps_left,
    output logic [2:0]        state
);

    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    seq_state_t        cur, nxt;
    logic [N_W-1:0]    steps_q, steps_d;
    logic              init_seen, init_seen_d;
    logic              s1_seen, s1_seen_d;
    logic [7:0]        drain_q, drain_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              valid_q, valid_d;
    logic              wdog_en, wdog_clr, wdog_expired;
    logic              progress, both_seen;

    assign progress  = done_init | done_s1 | step_done;
    assign both_seen = (init_seen | done_init) & (s1_seen | done_s1);

    always_comb begin
        nxt         = cur;
        steps_d     = steps_q;
        init_seen_d = init_seen;
        s1_seen_d   = s1_seen;
        drain_d     = drain_q;
        result_d    = result_q;
        valid_d     = valid_q;

        if (abort) begin
            nxt         = IDLE;
            valid_d     = 1'b0;
            steps_d     = '0;
            init_seen_d = 1'b0;
            s1_seen_d   = 1'b0;
            drain_d     = '0;
        end else begin
            case (cur)
                IDLE: begin
                    if (req) begin
                        steps_d     = n_steps;
                        init_seen_d = 1'b0;
                        s1_seen_d   = 1'b0;
                        nxt         = INIT;
                    end
                end
                INIT: begin
                    init_seen_d = init_seen | done_init;
                    s1_seen_d   = s1_seen | done_s1;
                    nxt         = WAIT_S1;
                end
                WAIT_S1: begin
                    init_seen_d = init_seen | done_init;
                    s1_seen_d   = s1_seen | done_s1;
                    if (both_seen) begin
                        if (steps_q != '0) begin
                            nxt = RUN;
                        end else begin
                            nxt     = DRAIN;
                            drain_d = DRAIN_LOAD;
                        end
                    end else if (wdog_expired && !progress) begin
                        nxt = ERR;
                    end
                end
                RUN: begin
                    if (step_done) begin
                        if (steps_q != '0) begin
                            steps_d = steps_q - N_W'(1);
                        end
                        if (steps_q <= N_W'(1)) begin
                            nxt     = DRAIN;
                            drain_d = DRAIN_LOAD;
                        end
                    end else if (wdog_expired) begin
                        nxt = ERR;
                    end
                end
                DRAIN: begin
                    // Sample only once the eval pipeline and memory have settled.
                    if (drain_q == '0) begin
                        result_d = result_in;
                        valid_d  = 1'b1;
                        nxt      = HOLD;
                    end else begin
                        drain_d = drain_q - 8'd1;
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        valid_d = 1'b0;
                        nxt     = IDLE;
                    end
                end
                ERR: begin
                    nxt = ERR;
                end
                default: begin
                    nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cur       <= IDLE;
            steps_q   <= '0;
            init_seen <= 1'b0;
            s1_seen   <= 1'b0;
            drain_q   <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            cur       <= nxt;
            steps_q   <= steps_d;
            init_seen <= init_seen_d;
            s1_seen   <= s1_seen_d;
            drain_q   <= drain_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    // Clearing on any state change gives every watched state a fresh budget.
    assign wdog_en  = (cur == INIT) || (cur == WAIT_S1) || (cur == RUN);
    assign wdog_clr = (nxt != cur) || progress;

    seq_watchdog #(
        .WDOG_W(WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .nrst    (nrst),
        .en      (wdog_en),
        .clr     (wdog_clr),
        .expired (wdog_expired)
    );

    assign ack          = (cur == INIT);
    assign start_s1     = (cur == INIT);
    assign busy         = (cur != IDLE);
    assign error        = (cur == ERR);
    assign result       = result_q;
    assign result_valid = valid_q;
    assign steps_left   = steps_q;
    assign state        = cur;

endmodule

// File: tb/tb_amer_put_seq.sv
// tb/tb_amer_put_seq.sv - self-checking bench for amer_put_seq
module tb_amer_put_seq;

    localparam int DRAIN = 12;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req = 1'b0;
    logic        ack;
    logic [15:0] n_steps = '0;
    logic        abort = 1'b0;
    logic        start_s1;
    logic        done_init = 1'b0;
    logic        done_s1 = 1'b0;
    logic        step_done = 1'b0;
    logic [63:0] result_in = '0;
    logic [63:0] result;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        busy;
    logic        error;
    logic [15:0] steps_left;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int s1_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_result = '0;

    always #5 clk = ~clk;

    amer_put_seq #(
        .N_W(16),
        .DRAIN_CYCLES(DRAIN),
        .WDOG_W(6)
    ) dut (
        .clk(clk), .nrst(nrst), .req(req), .ack(ack), .n_steps(n_steps),
        .abort(abort), .start_s1(start_s1), .done_init(done_init),
        .done_s1(done_s1), .step_done(step_done), .result_in(result_in),
        .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .error(error),
        .steps_left(steps_left), .state(state)
    );

    always @(negedge clk) begin
        if (ack === 1'b1) ack_cnt++;
        if (start_s1 === 1'b1) s1_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] n;
        int          d_init;
        int          d_s1;
        int          gap;
        int          extra;
        int          hold;
        bit          req_hold;
        logic [63:0] value;
        int          exp_lat;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int a0, s0, maxd, lat;
        logic [63:0] got;
        a0 = ack_cnt;
        s0 = s1_cnt;
        maxd = (v.d_init > v.d_s1) ? v.d_init : v.d_s1;
        exp_q.push_back(v.value);
        result_in = ~v.value;
        req = 1'b1;
        n_steps = v.n;
        tick();
        check("accept_state", 64'(state), 64'd1);
        check("ack_pulse", 64'(ack), 64'd1);
        check("start_s1_pulse", 64'(start_s1), 64'd1);
        check("steps_loaded", 64'(steps_left), 64'(v.n));
        if (!v.req_hold) req = 1'b0;
        n_steps = 16'hffff;
        done_init = (v.d_init == 0);
        done_s1 = (v.d_s1 == 0);
        for (int c = 1; c <= maxd; c++) begin
            tick();
            check("wait_s1_state", 64'(state), 64'd2);
            done_init = (c == v.d_init);
            done_s1 = (c == v.d_s1);
        end
        tick();
        done_init = 1'b0;
        done_s1 = 1'b0;
        check("after_wait_state", 64'(state), (v.n != 0) ? 64'd3 : 64'd4);
        check("steps_on_run", 64'(steps_left), 64'(v.n));
        for (int k = 1; k <= int'(v.n); k++) begin
            repeat (v.gap - 1) tick();
            step_done = 1'b1;
            tick();
            step_done = 1'b0;
            check("steps_dec", 64'(steps_left), 64'(int'(v.n) - k));
        end
        if (v.n != 0) check("drain_entry", 64'(state), 64'd4);
        result_in = v.value;
        lat = 0;
        while (!result_valid && lat < 300) begin
            step_done = (lat < v.extra);
            tick();
            step_done = 1'b0;
            lat++;
        end
        check("valid_latency", 64'(lat), 64'(v.exp_lat));
        check("steps_zero", 64'(steps_left), 64'd0);
        result_in = 64'hdead_beef_dead_beef;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=empty required=entry");
        end else begin
            got = exp_q.pop_front();
            check("result_value", result, got);
        end
        for (int h = 0; h < v.hold; h++) begin
            tick();
            check("hold_valid", 64'(result_valid), 64'd1);
            check("hold_result", result, v.value);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("exit_idle", 64'(state), 64'd0);
        check("exit_valid", 64'(result_valid), 64'd0);
        check("result_kept", result, v.value);
        check("ack_once", 64'(ack_cnt - a0), 64'd1);
        check("start_once", 64'(s1_cnt - s0), 64'd1);
        last_result = v.value;
    endtask

    vec_t vecs[5];

    initial begin
        int c, a0, s0;
        vecs[0] = '{16'd3, 5, 9, 20, 0, 3, 1'b0, 64'h4010_0000_0000_0000, DRAIN};
        vecs[1] = '{16'd2, 7, 3, 4, 0, 0, 1'b0, 64'h0123_4567_89ab_cdef, DRAIN};
        vecs[2] = '{16'd4, 6, 6, 1, 0, 1, 1'b0, 64'hc000_1111_2222_3333, DRAIN};
        vecs[3] = '{16'd0, 2, 4, 1, 3, 0, 1'b0, 64'h3ff0_0000_0000_0000, DRAIN};
        vecs[4] = '{16'd1, 0, 1, 2, 0, 2, 1'b1, 64'h7777_8888_9999_aaaa, DRAIN};

        repeat (3) tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_err", 64'(error), 64'd0);
        check("rst_steps", 64'(steps_left), 64'd0);
        nrst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // abort mid-RUN with two levels left
        req = 1'b1;
        n_steps = 16'd3;
        tick();
        req = 1'b0;
        tick();
        done_init = 1'b1;
        done_s1 = 1'b1;
        tick();
        done_init = 1'b0;
        done_s1 = 1'b0;
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        check("abort_pre_steps", 64'(steps_left), 64'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 64'(state), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(result_valid), 64'd0);
        check("abort_result", result, last_result);
        check("abort_steps", 64'(steps_left), 64'd0);

        // req held through HOLD: second accept only after HOLD exits
        run_vec(vecs[4]);
        check("held_idle_ack", 64'(ack), 64'd0);
        a0 = ack_cnt;
        s0 = s1_cnt;
        tick();
        check("held_reaccept", 64'(state), 64'd1);
        abort = 1'b1;
        req = 1'b0;
        tick();
        abort = 1'b0;
        check("init_abort_state", 64'(state), 64'd0);
        check("init_abort_start", 64'(s1_cnt - s0), 64'd1);
        check("init_abort_ack", 64'(ack_cnt - a0), 64'd1);

        // watchdog: no done_init after start
        req = 1'b1;
        n_steps = 16'd2;
        tick();
        req = 1'b0;
        c = 0;
        while (!error && c < 200) begin
            tick();
            c++;
            if (c == 60) check("wdog_early", 64'(error), 64'd0);
        end
        check("wdog_window", 64'(c >= 62 && c <= 66), 64'd1);
        check("wdog_state", 64'(state), 64'd6);
        check("wdog_busy", 64'(busy), 64'd1);
        a0 = ack_cnt;
        req = 1'b1;
        tick();
        tick();
        req = 1'b0;
        check("err_ignores_req", 64'(state), 64'd6);
        check("err_no_ack", 64'(ack_cnt - a0), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("err_abort_state", 64'(state), 64'd0);
        check("err_abort_error", 64'(error), 64'd0);

        run_vec(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
